mem_arbiter: RTL and testbench

Sequential arbiter that shares the single-port 256×16 RAM between the CPU datapath (CPU port) and an external debug/program-loader port (DBG port). It serialises requests into one RAM access at a time, paced by SLOW_CLOCK_STRB, and returns read data with a per-port acknowledge. It sits between the requesters and the RAM's WRITE_EN/ADDRESS/DATA_IN/DATA_OUT pins.

---
 rtl/mem_arb_pkg.sv | 15 +
 rtl/mem_arbiter_if.sv | 40 ++++
 rtl/mem_arb_pick.sv | 33 +++
 rtl/mem_arbiter.sv | 89 ++++++++
 tb/tb_mem_arbiter.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the CPU/DBG memory arbiter.
package mem_arb_pkg;
   localparam int ADDR_W_DEF = 8;
   localparam int DATA_W_DEF = 16;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      CAPTURE = 2'd2,
      DONE    = 2'd3
   } arb_state_e;

   localparam logic OWNER_CPU = 1'b0;
   localparam logic OWNER_DBG = 1'b1;
endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and RAM buses of the arbiter; slave = arbiter side, master = requesters/RAM side.
interface mem_arbiter_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 16
);
   logic              cpu_req;
   logic              cpu_wr;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic              cpu_ack;
   logic [DATA_W-1:0] cpu_rdata;

   logic              dbg_req;
   logic              dbg_wr;
   logic [ADDR_W-1:0] dbg_addr;
   logic [DATA_W-1:0] dbg_wdata;
   logic              dbg_ack;
   logic [DATA_W-1:0] dbg_rdata;

   logic              ram_wr;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_wdata;
   logic [DATA_W-1:0] ram_rdata;

   modport slave (
      input  cpu_req, cpu_wr, cpu_addr, cpu_wdata,
      input  dbg_req, dbg_wr, dbg_addr, dbg_wdata,
      input  ram_rdata,
      output cpu_ack, cpu_rdata, dbg_ack, dbg_rdata,
      output ram_wr, ram_addr, ram_wdata
   );

   modport master (
      output cpu_req, cpu_wr, cpu_addr, cpu_wdata,
      output dbg_req, dbg_wr, dbg_addr, dbg_wdata,
      output ram_rdata,
      input  cpu_ack, cpu_rdata, dbg_ack, dbg_rdata,
      input  ram_wr, ram_addr, ram_wdata
   );
endinterface

// File: rtl/mem_arb_pick.sv
// Winner select between the CPU and DBG ports.
// MEM_ARB_ROUND_ROBIN_EN: ties go to the port not served last; otherwise CPU wins ties.
module mem_arb_pick
   import mem_arb_pkg::*;
(
   input  logic cpu_elig,
   input  logic dbg_elig,
   input  logic last_served,
   output logic grant_any,
   output logic winner
);
   assign grant_any = cpu_elig | dbg_elig;

`ifdef MEM_ARB_ROUND_ROBIN_EN
   always_comb begin
      winner = OWNER_CPU;
      if (cpu_elig && dbg_elig)
         winner = (last_served == OWNER_CPU) ? OWNER_DBG : OWNER_CPU;
      else if (dbg_elig)
         winner = OWNER_DBG;
   end
`else
   // Fixed priority has no use for history.
   logic unused_last;
   assign unused_last = last_served;

   always_comb begin
      winner = OWNER_CPU;
      if (!cpu_elig && dbg_elig)
         winner = OWNER_DBG;
   end
`endif
endmodule

// File: rtl/mem_arbiter.sv
// Serialises CPU and DBG accesses onto one single-port RAM, one access per four ticks.
// Tie policy selected by MEM_ARB_ROUND_ROBIN_EN (see mem_arb_pick).
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic          clk,
   input  logic          arst_l,
   input  logic          slow_clock_strb,
   input  logic          halt,
   mem_arbiter_if.slave  bus,
   output logic          busy,
   output logic          owner
);
   arb_state_e state;
   logic       lat_wr;
   logic       last_served;
   logic       cpu_elig;
   logic       dbg_elig;
   logic       grant_any;
   logic       grant_dbg;

   // HALT only gates new CPU grants; an in-flight CPU access runs to completion.
   assign cpu_elig = bus.cpu_req & ~halt;
   assign dbg_elig = bus.dbg_req;

   mem_arb_pick u_pick (
      .cpu_elig    (cpu_elig),
      .dbg_elig    (dbg_elig),
      .last_served (last_served),
      .grant_any   (grant_any),
      .winner      (grant_dbg)
   );

   always_ff @(posedge clk) begin
      if (!arst_l) begin
         state         <= IDLE;
         lat_wr        <= 1'b0;
         last_served   <= OWNER_DBG;
         owner         <= OWNER_CPU;
         busy          <= 1'b0;
         bus.ram_wr    <= 1'b0;
         bus.ram_addr  <= '0;
         bus.ram_wdata <= '0;
         bus.cpu_ack   <= 1'b0;
         bus.dbg_ack   <= 1'b0;
         bus.cpu_rdata <= '0;
         bus.dbg_rdata <= '0;
      end else if (slow_clock_strb) begin
         case (state)
            IDLE: begin
               if (grant_any) begin
                  // Request fields are latched here; later changes on the bus are ignored.
                  state         <= ISSUE;
                  busy          <= 1'b1;
                  owner         <= grant_dbg;
                  last_served   <= grant_dbg;
                  lat_wr        <= grant_dbg ? bus.dbg_wr    : bus.cpu_wr;
                  bus.ram_wr    <= grant_dbg ? bus.dbg_wr    : bus.cpu_wr;
                  bus.ram_addr  <= grant_dbg ? bus.dbg_addr  : bus.cpu_addr;
                  bus.ram_wdata <= grant_dbg ? bus.dbg_wdata : bus.cpu_wdata;
               end
            end
            ISSUE: begin
               state      <= CAPTURE;
               bus.ram_wr <= 1'b0;
            end
            CAPTURE: begin
               state <= DONE;
               if (!lat_wr) begin
                  if (owner == OWNER_DBG) bus.dbg_rdata <= bus.ram_rdata;
                  else                    bus.cpu_rdata <= bus.ram_rdata;
               end
               bus.cpu_ack <= (owner == OWNER_CPU);
               bus.dbg_ack <= (owner == OWNER_DBG);
            end
            DONE: begin
               state       <= IDLE;
               busy        <= 1'b0;
               bus.cpu_ack <= 1'b0;
               bus.dbg_ack <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table, hand-written corner sequences, random traffic vs. a reference model.
module tb_mem_arbiter;
   import mem_arb_pkg::*;

`ifdef MEM_ARB_ROUND_ROBIN_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic clk = 1'b0;
   logic arst_l, strobe, halt, busy, owner, ram_clear;
   int   n_tests = 0;
   int   n_fail  = 0;
   int   tdiv    = 1;

   mem_arbiter_if #(.ADDR_W(8), .DATA_W(16)) bus ();

   mem_arbiter dut (
      .clk             (clk),
      .arst_l          (arst_l),
      .slow_clock_strb (strobe),
      .halt            (halt),
      .bus             (bus),
      .busy            (busy),
      .owner           (owner)
   );

   always #5 clk = ~clk;

   // RAM: synchronous read, writes and reads advance on ticks only; not reset by arst_l.
   logic [15:0] mem [256];
   always @(posedge clk) begin
      if (ram_clear) mem <= '{default: 16'h0};
      else if (strobe) begin
         if (bus.ram_wr) mem[bus.ram_addr] <= bus.ram_wdata;
         bus.ram_rdata <= mem[bus.ram_addr];
      end
   end

   // Reference model state
   logic [15:0] model_mem [256];
   logic [15:0] exp_cpu_rdata, exp_dbg_rdata;
   logic        model_last;

   function automatic logic model_pick(input logic cpu_e, input logic dbg_e);
      if (cpu_e && dbg_e) return RR ? ~model_last : OWNER_CPU;
      return dbg_e ? OWNER_DBG : OWNER_CPU;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      strobe = 1'b0;
      repeat (tdiv - 1) @(negedge clk);
      strobe = 1'b1;
      @(negedge clk);
      strobe = 1'b0;
   endtask

   // One full access from the acceptance tick back to IDLE; requests must already be driven.
   task automatic access(input logic w, input logic wr, input logic [7:0] a,
                         input logic [15:0] d, input bit drop);
      tick();
      chk("busy_accept", busy, 1);
      chk("owner", owner, w);
      chk("ram_wr_issue", bus.ram_wr, wr);
      chk("ram_addr", bus.ram_addr, a);
      if (wr) chk("ram_wdata", bus.ram_wdata, d);
      // Post-acceptance changes must not disturb the access.
      bus.cpu_wr = 1'($urandom); bus.dbg_wr = 1'($urandom);
      bus.cpu_addr = 8'($urandom); bus.dbg_addr = 8'($urandom);
      bus.cpu_wdata = 16'($urandom); bus.dbg_wdata = 16'($urandom);
      tick();
      chk("ram_wr_capture", bus.ram_wr, 0);
      chk("ack_early", {bus.cpu_ack, bus.dbg_ack}, 0);
      tick();
      if (wr) model_mem[a] = d;
      else if (w == OWNER_DBG) exp_dbg_rdata = model_mem[a];
      else exp_cpu_rdata = model_mem[a];
      chk("cpu_ack_done", bus.cpu_ack, (w == OWNER_CPU));
      chk("dbg_ack_done", bus.dbg_ack, (w == OWNER_DBG));
      chk("cpu_rdata", bus.cpu_rdata, exp_cpu_rdata);
      chk("dbg_rdata", bus.dbg_rdata, exp_dbg_rdata);
      if (drop) begin bus.cpu_req = 1'b0; bus.dbg_req = 1'b0; end
      tick();
      chk("ack_fall", {bus.cpu_ack, bus.dbg_ack}, 0);
      chk("busy_idle", busy, 0);
      model_last = w;
   endtask

   typedef struct {
      logic none, cr, dr, h, cw, dw;
      logic [7:0] ca, da;
      logic [15:0] cd, dd;
      logic eo;
      logic [15:0] er;
      int div;
   } vec_t;

   vec_t tbl [9];

   initial begin
      logic w, wr;
      logic [7:0] a;
      logic [15:0] d;
      bit flag;

      // none, cpu_req, dbg_req, halt, cpu_wr, dbg_wr, cpu_addr, dbg_addr, cpu_wdata, dbg_wdata, owner, rdata, div
      tbl[0] = '{0, 1, 0, 0, 1, 0, 8'h10, 8'h00, 16'h1234, 16'h0000, OWNER_CPU, 16'h0000, 4};
      tbl[1] = '{0, 0, 1, 0, 0, 0, 8'h00, 8'h10, 16'h0000, 16'h0000, OWNER_DBG, 16'h1234, 4};
      tbl[2] = '{0, 0, 1, 0, 0, 1, 8'h00, 8'h20, 16'h0000, 16'hBEEF, OWNER_DBG, 16'h0000, 2};
      tbl[3] = '{0, 1, 0, 0, 0, 0, 8'h20, 8'h00, 16'h0000, 16'h0000, OWNER_CPU, 16'hBEEF, 2};
      tbl[4] = '{0, 1, 1, 1, 1, 1, 8'h30, 8'h31, 16'h7777, 16'h5555, OWNER_DBG, 16'h0000, 2};
      tbl[5] = '{0, 1, 1, 0, 0, 0, 8'h31, 8'h10, 16'h0000, 16'h0000, OWNER_CPU, 16'h5555, 2};
      tbl[6] = '{0, 1, 1, 0, 0, 0, 8'h10, 8'h20, 16'h0000, 16'h0000,
                 RR ? OWNER_DBG : OWNER_CPU, RR ? 16'hBEEF : 16'h1234, 1};
      tbl[7] = '{0, 1, 1, 1, 0, 0, 8'h00, 8'h30, 16'h0000, 16'h0000, OWNER_DBG, 16'h0000, 1};
      tbl[8] = '{1, 1, 0, 1, 1, 0, 8'h40, 8'h00, 16'h0000, 16'h0000, OWNER_CPU, 16'h0000, 3};

      for (int i = 0; i < 256; i++) model_mem[i] = 16'h0;
      exp_cpu_rdata = 16'h0; exp_dbg_rdata = 16'h0; model_last = OWNER_DBG;

      arst_l = 1'b0; ram_clear = 1'b1; strobe = 1'b0; halt = 1'b0;
      bus.cpu_req = 0; bus.cpu_wr = 0; bus.cpu_addr = 0; bus.cpu_wdata = 0;
      bus.dbg_req = 0; bus.dbg_wr = 0; bus.dbg_addr = 0; bus.dbg_wdata = 0;
      repeat (3) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_owner", owner, OWNER_CPU);
      chk("rst_acks", {bus.cpu_ack, bus.dbg_ack}, 0);
      chk("rst_ram", {bus.ram_wr, bus.ram_addr, bus.ram_wdata}, 0);
      chk("rst_rdata", {bus.cpu_rdata, bus.dbg_rdata}, 0);
      arst_l = 1'b1; ram_clear = 1'b0;

      // Vector table
      for (int i = 0; i < 9; i++) begin
         tdiv = tbl[i].div; halt = tbl[i].h;
         bus.cpu_req = tbl[i].cr; bus.dbg_req = tbl[i].dr;
         bus.cpu_wr = tbl[i].cw; bus.dbg_wr = tbl[i].dw;
         bus.cpu_addr = tbl[i].ca; bus.dbg_addr = tbl[i].da;
         bus.cpu_wdata = tbl[i].cd; bus.dbg_wdata = tbl[i].dd;
         if (tbl[i].none) begin
            repeat (3) tick();
            chk("tbl_idle_busy", busy, 0);
            chk("tbl_idle_ack", {bus.cpu_ack, bus.dbg_ack}, 0);
            bus.cpu_req = 1'b0; bus.dbg_req = 1'b0;
         end else begin
            w  = tbl[i].eo;
            wr = w ? tbl[i].dw : tbl[i].cw;
            a  = w ? tbl[i].da : tbl[i].ca;
            d  = w ? tbl[i].dd : tbl[i].cd;
            access(w, wr, a, d, 1'b1);
            if (!wr) chk("tbl_rdata", w ? bus.dbg_rdata : bus.cpu_rdata, tbl[i].er);
         end
      end
      halt = 1'b0;

      // HALT raised mid CPU access: it completes, next grant goes to DBG
      tdiv = 2;
      bus.cpu_req = 1; bus.cpu_wr = 0; bus.cpu_addr = 8'h10; bus.dbg_req = 0;
      tick();
      chk("halt_owner", owner, OWNER_CPU);
      halt = 1'b1; bus.dbg_req = 1; bus.dbg_wr = 0; bus.dbg_addr = 8'h20;
      tick(); tick();
      exp_cpu_rdata = model_mem[8'h10];
      chk("halt_cpu_ack", bus.cpu_ack, 1);
      chk("halt_dbg_ack", bus.dbg_ack, 0);
      chk("halt_cpu_rdata", bus.cpu_rdata, exp_cpu_rdata);
      tick();
      chk("halt_ack_fall", bus.cpu_ack, 0);
      model_last = OWNER_CPU;
      access(OWNER_DBG, 1'b0, 8'h20, 16'h0, 1'b1);
      halt = 1'b0;

      // Reset during CAPTURE of a CPU read aborts it without an ACK
      bus.cpu_req = 1; bus.cpu_wr = 0; bus.cpu_addr = 8'h20; bus.dbg_req = 0;
      tick(); tick();
      chk("pre_rst_busy", busy, 1);
      arst_l = 1'b0;
      @(negedge clk);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_ack", {bus.cpu_ack, bus.dbg_ack}, 0);
      chk("mid_rst_rdata", {bus.cpu_rdata, bus.dbg_rdata}, 0);
      chk("mid_rst_owner", owner, OWNER_CPU);
      arst_l = 1'b1; bus.cpu_req = 0;
      exp_cpu_rdata = 16'h0; exp_dbg_rdata = 16'h0; model_last = OWNER_DBG;
      flag = 0;
      repeat (4) begin tick(); flag |= bus.cpu_ack | bus.dbg_ack | busy; end
      chk("post_rst_quiet", flag, 0);

      // Strobe held low: no progress, then first strobe accepts (strobe tied high)
      bus.cpu_req = 1; bus.cpu_wr = 1; bus.cpu_addr = 8'h50; bus.cpu_wdata = 16'hA5A5;
      strobe = 1'b0; flag = 0;
      repeat (20) begin @(negedge clk); flag |= busy; end
      chk("no_strobe_busy", flag, 0);
      tdiv = 1;
      access(OWNER_CPU, 1'b1, 8'h50, 16'hA5A5, 1'b1);
      bus.dbg_req = 1; bus.dbg_wr = 0; bus.dbg_addr = 8'h50;
      access(OWNER_DBG, 1'b0, 8'h50, 16'h0, 1'b1);

      // Continuous requests on both ports
      for (int k = 0; k < 4; k++) begin
         bus.cpu_req = 1; bus.dbg_req = 1;
         bus.cpu_wr = 0; bus.dbg_wr = 0; bus.cpu_addr = 8'h10; bus.dbg_addr = 8'h20;
         w = model_pick(1'b1, 1'b1);
         access(w, 1'b0, w ? 8'h20 : 8'h10, 16'h0, 1'b0);
      end
      bus.cpu_req = 0; bus.dbg_req = 0;
      repeat (4) tick();

      // Random traffic against the reference model
      for (int k = 0; k < 60; k++) begin
         tdiv = int'($urandom_range(1, 3));
         halt = ($urandom_range(0, 3) == 0);
         bus.cpu_req = 1'($urandom); bus.dbg_req = 1'($urandom);
         bus.cpu_wr = 1'($urandom); bus.dbg_wr = 1'($urandom);
         bus.cpu_addr = 8'h40 + 8'($urandom_range(0, 3));
         bus.dbg_addr = 8'h40 + 8'($urandom_range(0, 3));
         bus.cpu_wdata = 16'($urandom); bus.dbg_wdata = 16'($urandom);
         if (!(bus.cpu_req && !halt) && !bus.dbg_req) begin
            tick();
            chk("rnd_idle_busy", busy, 0);
            chk("rnd_idle_ack", {bus.cpu_ack, bus.dbg_ack}, 0);
         end else begin
            w  = model_pick(bus.cpu_req && !halt, bus.dbg_req);
            wr = w ? bus.dbg_wr : bus.cpu_wr;
            a  = w ? bus.dbg_addr : bus.cpu_addr;
            d  = w ? bus.dbg_wdata : bus.cpu_wdata;
            access(w, wr, a, d, 1'b1);
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
